// File: rtl/bcd_countdown_counter_if.sv
// Digit and control bundle shared by the BCD countdown counter and its user.
// The master side drives enable, load and preset digits; the counter returns its digits and status.
interface bcd_countdown_counter_if;
  logic       en;
  logic       load;
  logic [3:0] load_ones;
  logic [3:0] load_tens;
  logic [3:0] load_hundreds;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [3:0] hundreds;
  logic       busy;
  logic       done;

  modport master (
    output en, load, load_ones, load_tens, load_hundreds,
    input  ones, tens, hundreds, busy, done
  );

  modport slave (
    input  en, load, load_ones, load_tens, load_hundreds,
    output ones, tens, hundreds, busy, done
  );
endinterface

// File: rtl/bcd_countdown_counter.sv
// Three-decade BCD down counter with prescaler, preset reload and expiry flag.
// Counts a loaded 000-999 value down to 000; optionally restarts from the last preset.
module bcd_countdown_counter #(
  parameter int TICK_DIV    = 1,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input logic               clk,
  input logic               reset_n,
  bcd_countdown_counter_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    ones_q, tens_q, hund_q;
  logic [3:0]    ones_nx, tens_nx, hund_nx;
  logic [3:0]    pre_ones, pre_tens, pre_hund;
  logic [3:0]    pre_ones_nx, pre_tens_nx, pre_hund_nx;
  logic [PW-1:0] ps, ps_nx;
  logic          busy_q, done_q;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ones_q   <= 4'd0;
      tens_q   <= 4'd0;
      hund_q   <= 4'd0;
      pre_ones <= 4'd0;
      pre_tens <= 4'd0;
      pre_hund <= 4'd0;
      ps       <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      ones_q   <= ones_nx;
      tens_q   <= tens_nx;
      hund_q   <= hund_nx;
      pre_ones <= pre_ones_nx;
      pre_tens <= pre_tens_nx;
      pre_hund <= pre_hund_nx;
      ps       <= ps_nx;
      busy_q   <= (state_nx == RUN);
      done_q   <= (state_nx == EXPIRED);
    end
  end

  // Load beats counting; the decrement that lands on 000 enters EXPIRED on that same edge.
  always_comb begin
    state_nx    = state;
    ones_nx     = ones_q;
    tens_nx     = tens_q;
    hund_nx     = hund_q;
    pre_ones_nx = pre_ones;
    pre_tens_nx = pre_tens;
    pre_hund_nx = pre_hund;
    ps_nx       = ps;

    if (bus.load) begin
      ones_nx     = clamp9(bus.load_ones);
      tens_nx     = clamp9(bus.load_tens);
      hund_nx     = clamp9(bus.load_hundreds);
      pre_ones_nx = ones_nx;
      pre_tens_nx = tens_nx;
      pre_hund_nx = hund_nx;
      ps_nx       = '0;
      state_nx    = ({hund_nx, tens_nx, ones_nx} != 12'd0) ? RUN : IDLE;
    end else begin
      case (state)
        RUN: begin
          if (bus.en) begin
            if (ps == PS_LAST) begin
              ps_nx = '0;
              if (ones_q == 4'd0) begin
                ones_nx = 4'd9;
                if (tens_q == 4'd0) begin
                  tens_nx = 4'd9;
                  hund_nx = hund_q - 4'd1;
                end else begin
                  tens_nx = tens_q - 4'd1;
                end
              end else begin
                ones_nx = ones_q - 4'd1;
              end
              if (hund_q == 4'd0 && tens_q == 4'd0 && ones_q == 4'd1) begin
                state_nx = EXPIRED;
              end
            end else begin
              ps_nx = ps + PW'(1);
            end
          end
        end
        EXPIRED: begin
          if (AUTO_RELOAD) begin
            ones_nx  = pre_ones;
            tens_nx  = pre_tens;
            hund_nx  = pre_hund;
            ps_nx    = '0;
            state_nx = RUN;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ones     = ones_q;
  assign bus.tens     = tens_q;
  assign bus.hundreds = hund_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_bcd_countdown_counter.sv
// Scoreboard bench for bcd_countdown_counter: three instances cover plain, prescaled and auto-reload builds.
// An integer reference model pushes expected outputs per cycle; each test pops and compares them.
module tb_bcd_countdown_counter;

  typedef struct {
    int          id;
    logic [13:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  int mval [3];
  int mpre [3];
  int mps  [3];
  int mst  [3];
  int div_tab [3] = '{1, 4, 1};
  int ar_tab  [3] = '{0, 0, 1};

  bcd_countdown_counter_if if0 ();
  bcd_countdown_counter_if if1 ();
  bcd_countdown_counter_if if2 ();

  bcd_countdown_counter #(.TICK_DIV(1), .AUTO_RELOAD(1'b0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  bcd_countdown_counter #(.TICK_DIV(4), .AUTO_RELOAD(1'b0)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
  bcd_countdown_counter #(.TICK_DIV(1), .AUTO_RELOAD(1'b1)) dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));

  always #5 clk = ~clk;

  function automatic logic [13:0] get_out(input int id);
    case (id)
      0:       return {if0.hundreds, if0.tens, if0.ones, if0.busy, if0.done};
      1:       return {if1.hundreds, if1.tens, if1.ones, if1.busy, if1.done};
      default: return {if2.hundreds, if2.tens, if2.ones, if2.busy, if2.done};
    endcase
  endfunction

  function automatic logic [13:0] model_out(input int id);
    int v;
    v = mval[id];
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10), mst[id] == 1, mst[id] == 2};
  endfunction

  function automatic int clampi(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mval[k] = 0; mpre[k] = 0; mps[k] = 0; mst[k] = 0;
    end
  endtask

  task automatic idle_inputs();
    if0.en = 1'b0; if0.load = 1'b0; if0.load_ones = 4'd0; if0.load_tens = 4'd0; if0.load_hundreds = 4'd0;
    if1.en = 1'b0; if1.load = 1'b0; if1.load_ones = 4'd0; if1.load_tens = 4'd0; if1.load_hundreds = 4'd0;
    if2.en = 1'b0; if2.load = 1'b0; if2.load_ones = 4'd0; if2.load_tens = 4'd0; if2.load_hundreds = 4'd0;
  endtask

  // Drive one clock of stimulus to one instance, step every model, queue the expectation.
  task automatic drive_cycle(input int id, input logic en, input logic ld,
                             input logic [3:0] lh, input logic [3:0] lt, input logic [3:0] lo);
    exp_t e;
    logic ke, kl;
    int   v;
    @(negedge clk);
    idle_inputs();
    case (id)
      0: begin if0.en = en; if0.load = ld; if0.load_hundreds = lh; if0.load_tens = lt; if0.load_ones = lo; end
      1: begin if1.en = en; if1.load = ld; if1.load_hundreds = lh; if1.load_tens = lt; if1.load_ones = lo; end
      default: begin if2.en = en; if2.load = ld; if2.load_hundreds = lh; if2.load_tens = lt; if2.load_ones = lo; end
    endcase
    for (int k = 0; k < 3; k++) begin
      ke = (k == id) && en;
      kl = (k == id) && ld;
      if (kl) begin
        v = clampi(lh) * 100 + clampi(lt) * 10 + clampi(lo);
        mval[k] = v; mpre[k] = v; mps[k] = 0; mst[k] = (v != 0) ? 1 : 0;
      end else if (mst[k] == 1 && ke) begin
        if (mps[k] == div_tab[k] - 1) begin
          mps[k] = 0;
          mval[k] = mval[k] - 1;
          if (mval[k] == 0) mst[k] = 2;
        end else begin
          mps[k] = mps[k] + 1;
        end
      end else if (mst[k] == 2 && ar_tab[k] == 1) begin
        mval[k] = mpre[k]; mps[k] = 0; mst[k] = 1;
      end
    end
    e.id  = id;
    e.val = model_out(id);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] got;
    for (int k = 0; k < 3; k++) begin
      got = get_out(k);
      checks++;
      if (got !== 14'h0000) begin
        failures++;
        $display("[TB] FAIL reset_state dut=%0d got=%h expected=%h", k, got, 14'h0000);
      end
    end
  endtask

  task automatic test_count_999();
    exp_t e;
    logic [13:0] got;
    drive_cycle(0, 1'b0, 1'b1, 4'd9, 4'd9, 4'd9);
    e = exp_q.pop_front(); got = get_out(e.id); checks++;
    if (got !== {12'h999, 2'b10}) begin
      failures++; $display("[TB] FAIL load999 got=%h expected=%h", got, {12'h999, 2'b10});
    end
    for (int k = 1; k <= 1002; k++) begin
      drive_cycle(0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
      e = exp_q.pop_front(); got = get_out(e.id); checks++;
      if (got !== e.val) begin
        failures++; $display("[TB] FAIL count999 edge=%0d got=%h expected=%h", k, got, e.val);
      end
      if (k == 900 || k == 990 || k == 998 || k >= 999) begin
        checks++;
        if (got !== ((k == 900) ? {12'h099, 2'b10} : (k == 990) ? {12'h009, 2'b10} :
                     (k == 998) ? {12'h001, 2'b10} : {12'h000, 2'b01})) begin
          failures++; $display("[TB] FAIL count999_point edge=%0d got=%h", k, got);
        end
      end
    end
  endtask

  task automatic test_prescaler();
    exp_t e;
    logic [13:0] got;
    drive_cycle(1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd3);
    e = exp_q.pop_front(); got = get_out(e.id); checks++;
    if (got !== e.val) begin
      failures++; $display("[TB] FAIL presc_load got=%h expected=%h", got, e.val);
    end
    for (int i = 0; i < 24; i++) begin
      drive_cycle(1, (i % 2) == 0, 1'b0, 4'd0, 4'd0, 4'd0);
      e = exp_q.pop_front(); got = get_out(e.id); checks++;
      if (got !== e.val) begin
        failures++; $display("[TB] FAIL prescaler cycle=%0d got=%h expected=%h", i, got, e.val);
      end
      if (i == 21 || i == 23) begin
        checks++;
        if (got !== ((i == 21) ? {12'h001, 2'b10} : {12'h000, 2'b01})) begin
          failures++; $display("[TB] FAIL prescaler_point cycle=%0d got=%h", i, got);
        end
      end
    end
  endtask

  task automatic test_auto_reload();
    exp_t e;
    logic [13:0] got;
    logic [13:0] seq [6];
    seq = '{{12'h001, 2'b10}, {12'h000, 2'b01}, {12'h002, 2'b10},
            {12'h001, 2'b10}, {12'h000, 2'b01}, {12'h002, 2'b10}};
    drive_cycle(2, 1'b0, 1'b1, 4'd0, 4'd0, 4'd2);
    e = exp_q.pop_front(); got = get_out(e.id); checks++;
    if (got !== {12'h002, 2'b10}) begin
      failures++; $display("[TB] FAIL reload_load got=%h expected=%h", got, {12'h002, 2'b10});
    end
    for (int i = 0; i < 6; i++) begin
      drive_cycle(2, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
      e = exp_q.pop_front(); got = get_out(e.id); checks++;
      if (got !== e.val || got !== seq[i]) begin
        failures++; $display("[TB] FAIL auto_reload step=%0d got=%h expected=%h", i, got, seq[i]);
      end
    end
  endtask

  task automatic test_edge_cases();
    exp_t e;
    logic [13:0] got;
    logic [13:0] want [5];
    want = '{{12'h000, 2'b00}, {12'h199, 2'b10}, {12'h002, 2'b10}, {12'h001, 2'b10}, {12'h050, 2'b10}};
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: drive_cycle(0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0);
        1: drive_cycle(0, 1'b0, 1'b1, 4'd1, 4'hA, 4'hC);
        2: drive_cycle(0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd2);
        3: drive_cycle(0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        4: drive_cycle(0, 1'b1, 1'b1, 4'd0, 4'd5, 4'd0);
        default: drive_cycle(0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
      endcase
      e = exp_q.pop_front(); got = get_out(e.id); checks++;
      if (got !== e.val || (i < 5 && got !== want[i]) || (i == 5 && got !== {12'h049, 2'b10})) begin
        failures++; $display("[TB] FAIL edge_case step=%0d got=%h expected=%h", i, got, e.val);
      end
    end
  endtask

  task automatic test_freeze();
    exp_t e;
    logic [13:0] got;
    drive_cycle(0, 1'b0, 1'b1, 4'd0, 4'd1, 4'd0);
    e = exp_q.pop_front(); got = get_out(e.id); checks++;
    if (got !== {12'h010, 2'b10}) begin
      failures++; $display("[TB] FAIL freeze_load got=%h expected=%h", got, {12'h010, 2'b10});
    end
    for (int i = 0; i < 30; i++) begin
      drive_cycle(0, (i < 3) || (i >= 23), 1'b0, 4'd0, 4'd0, 4'd0);
      e = exp_q.pop_front(); got = get_out(e.id); checks++;
      if (got !== e.val) begin
        failures++; $display("[TB] FAIL freeze cycle=%0d got=%h expected=%h", i, got, e.val);
      end
      if (i == 22 || i == 28 || i == 29) begin
        checks++;
        if (got !== ((i == 22) ? {12'h007, 2'b10} : (i == 28) ? {12'h001, 2'b10} : {12'h000, 2'b01})) begin
          failures++; $display("[TB] FAIL freeze_point cycle=%0d got=%h", i, got);
        end
      end
    end
  endtask

  task automatic test_reset_mid_count();
    exp_t e;
    logic [13:0] got;
    drive_cycle(0, 1'b0, 1'b1, 4'd1, 4'd2, 4'd3);
    e = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      drive_cycle(0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
      e = exp_q.pop_front();
    end
    got = get_out(0); checks++;
    if (got !== {12'h113, 2'b10}) begin
      failures++; $display("[TB] FAIL pre_reset got=%h expected=%h", got, {12'h113, 2'b10});
    end
    #2;
    reset_n = 1'b0;
    #1;
    got = get_out(0); checks++;
    if (got !== 14'h0000) begin
      failures++; $display("[TB] FAIL async_reset got=%h expected=%h", got, 14'h0000);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
      e = exp_q.pop_front(); got = get_out(e.id); checks++;
      if (got !== e.val || got !== 14'h0000) begin
        failures++; $display("[TB] FAIL post_reset_idle cycle=%0d got=%h expected=%h", i, got, 14'h0000);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    test_count_999();
    test_prescaler();
    test_auto_reload();
    test_edge_cases();
    test_freeze();
    test_reset_mid_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
